// File: rtl/eqv_pkg.sv
// Shared types and constants for the exhaustive-stimulus equivalence checker.
package eqv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        SAMPLE,
        DONE
    } eqv_state_t;

    localparam int DEFAULT_N_IN   = 2;
    localparam int DEFAULT_N_OUT  = 2;
    localparam int DEFAULT_SETTLE = 1;

    // Last vector of a run, zero-extended to the widest supported input count.
    function automatic logic [15:0] terminal_vec(input int n_in);
        return 16'((32'd1 << n_in) - 32'd1);
    endfunction

endpackage

// File: rtl/eqv_settle_timer.sv
// Settle-interval timer: counts cycles while enabled and flags the last one.
module eqv_settle_timer
    import eqv_pkg::*;
#(
    parameter int SETTLE = DEFAULT_SETTLE
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

    logic [CW-1:0] cnt;

    // Holds at the final count; the owner clears it before the next vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expire) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expire = enable && (cnt == LAST);

endmodule

// File: rtl/eqv_vector_checker.sv
// Exhaustive equivalence checker for two combinational circuits.
// Optional EQV_MISMATCH_COUNT_EN: visit every vector and count mismatches.
module eqv_vector_checker
    import eqv_pkg::*;
#(
    parameter int N_IN   = DEFAULT_N_IN,
    parameter int N_OUT  = DEFAULT_N_OUT,
    parameter int SETTLE = DEFAULT_SETTLE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [N_IN-1:0]   vec_out,
    input  logic [N_OUT-1:0]  out_a,
    input  logic [N_OUT-1:0]  out_b,
    output logic              busy,
    output logic              done,
    output logic              equiv,
    output logic [N_IN-1:0]   mismatch_vec,
    output logic [N_OUT-1:0]  mismatch_diff
`ifdef EQV_MISMATCH_COUNT_EN
    ,
    output logic [N_IN:0]     mismatch_cnt
`endif
);

    localparam logic [15:0] TERM_VEC = terminal_vec(N_IN);

    eqv_state_t       state;
    eqv_state_t       next_state;
    logic [N_OUT-1:0] diff;
    logic             is_terminal;
    logic             accept;
    logic             timer_clear;
    logic             settled;

    assign diff        = out_a ^ out_b;
    assign is_terminal = (16'(vec_out) == TERM_VEC);
    assign accept      = start && ((state == IDLE) || (state == DONE));
    assign timer_clear = accept || (state == SAMPLE);
    assign busy        = (state == APPLY) || (state == SAMPLE);
    assign done        = (state == DONE);

    eqv_settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (state == APPLY),
        .expire (settled)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    next_state = APPLY;
                end
            end
            APPLY: begin
                if (settled) begin
                    next_state = SAMPLE;
                end
            end
            SAMPLE: begin
`ifdef EQV_MISMATCH_COUNT_EN
                next_state = is_terminal ? DONE : APPLY;
`else
                if ((diff != '0) || is_terminal) begin
                    next_state = DONE;
                end else begin
                    next_state = APPLY;
                end
`endif
            end
            default: next_state = IDLE;
        endcase
    end

    // The terminal vector is recognised before incrementing, so vec_out never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_out       <= '0;
            equiv         <= 1'b0;
            mismatch_vec  <= '0;
            mismatch_diff <= '0;
`ifdef EQV_MISMATCH_COUNT_EN
            mismatch_cnt  <= '0;
`endif
        end else if (accept) begin
            vec_out       <= '0;
            equiv         <= 1'b0;
            mismatch_vec  <= '0;
            mismatch_diff <= '0;
`ifdef EQV_MISMATCH_COUNT_EN
            mismatch_cnt  <= '0;
`endif
        end else if (state == SAMPLE) begin
`ifdef EQV_MISMATCH_COUNT_EN
            if (diff != '0) begin
                mismatch_cnt <= mismatch_cnt + (N_IN+1)'(1);
                if (mismatch_cnt == '0) begin
                    mismatch_vec  <= vec_out;
                    mismatch_diff <= diff;
                end
            end
            if (is_terminal) begin
                equiv <= (mismatch_cnt == '0) && (diff == '0);
            end else begin
                vec_out <= vec_out + N_IN'(1);
            end
`else
            if (diff != '0) begin
                mismatch_vec  <= vec_out;
                mismatch_diff <= diff;
                equiv         <= 1'b0;
            end else if (is_terminal) begin
                equiv <= 1'b1;
            end else begin
                vec_out <= vec_out + N_IN'(1);
            end
`endif
        end
    end

endmodule

// File: tb/tb_eqv_vector_checker.sv
// Self-checking bench for eqv_vector_checker (N_IN=2, N_OUT=2, SETTLE=1).
// Build with EQV_MISMATCH_COUNT_EN to exercise the mismatch-count variant.
module tb_eqv_vector_checker;

    localparam int N_IN   = 2;
    localparam int N_OUT  = 2;
    localparam int SETTLE = 1;
    localparam int P      = SETTLE + 1;
    localparam int NV     = 1 << N_IN;
`ifdef EQV_MISMATCH_COUNT_EN
    localparam bit COUNT_MODE = 1'b1;
`else
    localparam bit COUNT_MODE = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [N_IN-1:0]  vec_out;
    logic [N_OUT-1:0] out_a;
    logic [N_OUT-1:0] out_b;
    logic             busy;
    logic             done;
    logic             equiv;
    logic [N_IN-1:0]  mismatch_vec;
    logic [N_OUT-1:0] mismatch_diff;
`ifdef EQV_MISMATCH_COUNT_EN
    logic [N_IN:0]    mismatch_cnt;
`endif

    int bmode    = 0;
    int run_mode = 0;
    int phase    = 0;
    int run_edge = 0;
    int edge_cnt = 0;
    int tests    = 0;
    int fails    = 0;
    bit chk_en   = 1'b0;

    eqv_vector_checker #(
        .N_IN   (N_IN),
        .N_OUT  (N_OUT),
        .SETTLE (SETTLE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .vec_out       (vec_out),
        .out_a         (out_a),
        .out_b         (out_b),
        .busy          (busy),
        .done          (done),
        .equiv         (equiv),
        .mismatch_vec  (mismatch_vec),
        .mismatch_diff (mismatch_diff)
`ifdef EQV_MISMATCH_COUNT_EN
        ,
        .mismatch_cnt  (mismatch_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Circuit A: O0 = I0|I1, O1 = ~I1.
    function automatic logic [1:0] circ_a(input logic [1:0] x);
        return {~x[1], x[0] | x[1]};
    endfunction

    // Circuit B: mode 0 is the equivalent form, mode 1 replaces O0 with I0&I1.
    function automatic logic [1:0] circ_b(input logic [1:0] x, input int m);
        if (m == 0) return {~x[1], x[1] | x[0]};
        return {~x[1], x[0] & x[1]};
    endfunction

    assign out_a = circ_a(vec_out);
    assign out_b = circ_b(vec_out, bmode);

    function automatic int first_mismatch(input int m);
        for (int v = 0; v < NV; v++) begin
            if (circ_a(2'(v)) != circ_b(2'(v), m)) return v;
        end
        return -1;
    endfunction

    function automatic int finish_k(input int m);
        int fm;
        fm = first_mismatch(m);
        if (!COUNT_MODE && fm >= 0) return (fm + 1) * P;
        return NV * P;
    endfunction

    // Expected {busy, done, equiv, vec_out, mismatch_vec, mismatch_diff, mismatch_cnt}
    // derived from the number of edges since the start was captured.
    function automatic logic [11:0] model_word();
        int         k;
        int         fm;
        int         fin;
        int         nmm;
        logic       b;
        logic       d;
        logic       eq;
        logic [1:0] v;
        logic [1:0] mv;
        logic [1:0] md;
        if (phase == 0) return 12'd0;
        k   = edge_cnt - run_edge;
        fm  = first_mismatch(run_mode);
        fin = finish_k(run_mode);
        b   = (k < fin);
        d   = !b;
        v   = b ? 2'(k / P) : 2'(fin / P - 1);
        eq  = d && (fm < 0);
        mv  = 2'd0;
        md  = 2'd0;
        if (fm >= 0 && k >= (fm + 1) * P) begin
            mv = 2'(fm);
            md = circ_a(2'(fm)) ^ circ_b(2'(fm), run_mode);
        end
        nmm = 0;
        if (COUNT_MODE) begin
            for (int i = 0; i < NV; i++) begin
                if (circ_a(2'(i)) != circ_b(2'(i), run_mode) && (i + 1) * P <= k) nmm++;
            end
        end
        return {b, d, eq, v, mv, md, 3'(nmm)};
    endfunction

    function automatic logic [11:0] dut_word();
        logic [2:0] c;
        c = 3'd0;
`ifdef EQV_MISMATCH_COUNT_EN
        c = mismatch_cnt;
`endif
        return {busy, done, equiv, vec_out, mismatch_vec, mismatch_diff, c};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            tests++;
            if (dut_word() !== model_word()) begin
                fails++;
                $display("[TB] FAIL cycle_model edge=%0d dut=%b model=%b",
                         edge_cnt, dut_word(), model_word());
            end
        end
    end

    // One clock of stimulus; the model follows the accept/ignore rule for start.
    task automatic applyStimulus(input bit s, input bit r);
        bit was_busy;
        @(negedge clk);
        start = s;
        rst   = r;
        @(posedge clk);
        #1;
        start = 1'b0;
        rst   = 1'b0;
        was_busy = (phase == 1) && ((edge_cnt - 1 - run_edge) < finish_k(run_mode));
        if (r) begin
            phase = 0;
        end else if (s && !was_busy) begin
            phase    = 1;
            run_edge = edge_cnt;
            run_mode = bmode;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
    endtask

    task automatic checkOutput(input string name, input logic [11:0] expected);
        tests++;
        if (dut_word() !== expected) begin
            fails++;
            $display("[TB] FAIL %s dut=%b expected=%b", name, dut_word(), expected);
        end
    endtask

    initial begin
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        chk_en = 1'b1;
        checkOutput("reset_state", 12'b0_0_0_00_00_00_000);

        bmode = 0;
        applyStimulus(1'b1, 1'b0);
        idle(7);
        checkOutput("equiv_k7_busy", 12'b1_0_0_11_00_00_000);
        idle(1);
        checkOutput("equiv_k8_done", 12'b0_1_1_11_00_00_000);

        bmode = 1;
        applyStimulus(1'b1, 1'b0);
        idle(4);
`ifdef EQV_MISMATCH_COUNT_EN
        checkOutput("mm_k4_counting", 12'b1_0_0_10_01_01_001);
        idle(4);
        checkOutput("mm_k8_done", 12'b0_1_0_11_01_01_010);
`else
        checkOutput("mm_k4_done", 12'b0_1_0_01_01_01_000);
        idle(4);
        checkOutput("mm_k8_held", 12'b0_1_0_01_01_01_000);
`endif

        bmode = 0;
        applyStimulus(1'b1, 1'b0);
        checkOutput("restart_cleared", 12'b1_0_0_00_00_00_000);
        idle(2);
        applyStimulus(1'b1, 1'b0);
        checkOutput("start_ignored_k3", 12'b1_0_0_01_00_00_000);
        idle(5);
        checkOutput("restart_k8_done", 12'b0_1_1_11_00_00_000);

        applyStimulus(1'b1, 1'b0);
        idle(4);
        applyStimulus(1'b0, 1'b1);
        checkOutput("midrun_reset", 12'b0_0_0_00_00_00_000);
        idle(1);
        applyStimulus(1'b1, 1'b0);
        idle(8);
        checkOutput("post_reset_done", 12'b0_1_1_11_00_00_000);

        applyStimulus(1'b1, 1'b1);
        checkOutput("rst_beats_start", 12'b0_0_0_00_00_00_000);
        idle(2);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
